// File: rtl/end_screen_ctrl.sv
// end_screen_ctrl
// Sequences the game-over screen. On game_over it freezes gameplay, slides
// the 272x138 end sprite from Y_START down to Y_FINAL one step per frame,
// blinks it, and waits for a restart press before requesting a game reset.
// It also mixes the end sprite pixel over the dimmed game pixel ahead of the
// VGA output register.
//
// Ports:
//   CLK           pixel clock
//   RST           asynchronous active-low reset
//   frame_tick    one-cycle pulse per frame (vsync start)
//   game_over     level from game logic
//   restart_btn   synchronized, debounced restart button level
//   game_pixel    RGB444 game-layer pixel, aligned with sprite data
//   spr_enable    end sprite enable, aligned with game_pixel
//   spr_data      end sprite RGB444 pixel, aligned with game_pixel
//   end_sprite_x  sprite x position to the end sprite block (constant)
//   end_sprite_y  sprite y position to the end sprite block
//   pixel_out     mixed pixel, registered (1-cycle latency)
//   game_freeze   halts game movement
//   game_reset    requests game-state reset
//   state         PLAY=0, SLIDE=1, SHOW=2, RESTART=3
module end_screen_ctrl #(
  parameter int unsigned X_POS           = 184,
  parameter int unsigned Y_START         = 0,
  parameter int unsigned Y_FINAL         = 171,
  parameter int unsigned SLIDE_STEP      = 4,
  parameter int unsigned BLINK_FRAMES    = 30,
  parameter int unsigned MIN_SHOW_FRAMES = 60,
  parameter logic [11:0] TRANSPARENT     = 12'h000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        frame_tick,
  input  logic        game_over,
  input  logic        restart_btn,
  input  logic [11:0] game_pixel,
  input  logic        spr_enable,
  input  logic [11:0] spr_data,
  output logic [9:0]  end_sprite_x,
  output logic [8:0]  end_sprite_y,
  output logic [11:0] pixel_out,
  output logic        game_freeze,
  output logic        game_reset,
  output logic [1:0]  state
);

  localparam logic [1:0] PLAY    = 2'd0;
  localparam logic [1:0] SLIDE   = 2'd1;
  localparam logic [1:0] SHOW    = 2'd2;
  localparam logic [1:0] RESTART = 2'd3;

  localparam int unsigned FW = $clog2(MIN_SHOW_FRAMES + 1);
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [8:0]    Y_START_V = 9'(Y_START);
  localparam logic [9:0]    Y_FINAL_W = 10'(Y_FINAL);
  localparam logic [FW-1:0] MIN_SHOW  = FW'(MIN_SHOW_FRAMES);
  localparam logic [BW-1:0] BLINK_END = BW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic [BW-1:0] blink_cnt;
  logic          visible;
  logic          btn_q;

  logic [9:0]    y_sum;
  logic          btn_rise;
  logic          show_spr;
  logic [11:0]   dimmed;
  logic [11:0]   mix;

  assign end_sprite_x = 10'(X_POS);
  assign game_freeze  = (state != PLAY);
  assign game_reset   = (state == RESTART);

  always_comb begin
    // 10-bit sum so the clamp comparison sees the true value near the bottom
    y_sum    = {1'b0, end_sprite_y} + 10'(SLIDE_STEP);
    btn_rise = restart_btn & ~btn_q;
    dimmed   = {1'b0, game_pixel[11:9], 1'b0, game_pixel[7:5], 1'b0, game_pixel[3:1]};
    // sprite is always visible while sliding; blinking only gates SHOW
    show_spr = ((state == SLIDE) || ((state == SHOW) && visible)) &&
               spr_enable && (spr_data != TRANSPARENT);
    if (show_spr)
      mix = spr_data;
    else if (state != PLAY)
      mix = dimmed;
    else
      mix = game_pixel;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= PLAY;
      end_sprite_y <= Y_START_V;
      frame_cnt    <= '0;
      blink_cnt    <= '0;
      visible      <= 1'b1;
      // starts high so a press held through reset does not count as an edge
      btn_q        <= 1'b1;
      pixel_out    <= '0;
    end else begin
      btn_q     <= restart_btn;
      pixel_out <= mix;
      case (state)
        PLAY: begin
          end_sprite_y <= Y_START_V;
          if (game_over)
            state <= SLIDE;
        end
        SLIDE: begin
          if (!game_over) begin
            state        <= PLAY;
            end_sprite_y <= Y_START_V;
            frame_cnt    <= '0;
            blink_cnt    <= '0;
            visible      <= 1'b1;
          end else if (frame_tick) begin
            if (y_sum >= Y_FINAL_W) begin
              end_sprite_y <= Y_FINAL_W[8:0];
              state        <= SHOW;
              frame_cnt    <= '0;
              blink_cnt    <= '0;
              visible      <= 1'b1;
            end else begin
              end_sprite_y <= y_sum[8:0];
            end
          end
        end
        SHOW: begin
          if (!game_over) begin
            state        <= PLAY;
            end_sprite_y <= Y_START_V;
            frame_cnt    <= '0;
            blink_cnt    <= '0;
            visible      <= 1'b1;
          end else if (btn_rise && (frame_cnt >= MIN_SHOW)) begin
            // a qualifying press wins over a coincident frame_tick
            state <= RESTART;
          end else if (frame_tick) begin
            if (frame_cnt < MIN_SHOW)
              frame_cnt <= frame_cnt + FW'(1);
            if (blink_cnt == BLINK_END) begin
              blink_cnt <= '0;
              visible   <= ~visible;
            end else begin
              blink_cnt <= blink_cnt + BW'(1);
            end
          end
        end
        default: begin
          if (!game_over) begin
            state        <= PLAY;
            end_sprite_y <= Y_START_V;
            frame_cnt    <= '0;
            blink_cnt    <= '0;
            visible      <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
